// File: rtl/rr_bus_arbiter_fsm.sv
// rtl/rr_bus_arbiter_fsm.sv - registered round-robin bus arbiter with grant hold and preemption
// Owner keeps the bus until done, req drop or MAX_HOLD; every handover inserts one idle GAP cycle.
module rr_bus_arbiter_fsm #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int ID_W     = $clog2(N),
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    done_i,
  output logic [N-1:0]    grant_o,
  output logic            grant_valid_o,
  output logic [ID_W-1:0] grant_id_o,
  output logic            preempt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [N-1:0]      grant_q, grant_d;
  logic              grant_valid_q, grant_valid_d;
  logic              preempt_q, preempt_d;

  logic [ID_W-1:0]   win_id;
  logic              owner_req;
  logic              owner_done;
  logic              at_limit;

  // Walk offsets from farthest to nearest so the nearest requester after last_id wins.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0]    r,
                                              input logic [ID_W-1:0] last);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = last;
    for (int k = N; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % N);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign win_id     = rr_pick(req_i, last_id_q);
  assign owner_req  = req_i[grant_id_q];
  assign owner_done = done_i[grant_id_q];
  assign at_limit   = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      last_id_q     <= ID_W'(N - 1);
      grant_id_q    <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      last_id_q     <= last_id_d;
      grant_id_q    <= grant_id_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    last_id_d     = last_id_q;
    grant_id_d    = grant_id_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (|req_i) begin
          state_d       = BUSY;
          hold_cnt_d    = '0;
          last_id_d     = win_id;
          grant_id_d    = win_id;
          grant_d       = N'(1) << win_id;
          grant_valid_d = 1'b1;
        end else begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end

      BUSY: begin
        if (owner_done || !owner_req || at_limit) begin
          state_d       = GAP;
          hold_cnt_d    = '0;
          grant_d       = '0;
          grant_valid_d = 1'b0;
          // A forced release only when the owner still wanted the bus.
          preempt_d     = at_limit && owner_req && !owner_done;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d       = IDLE;
        hold_cnt_d    = '0;
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    grant_o       = grant_q;
    grant_valid_o = grant_valid_q;
    grant_id_o    = grant_id_q;
    preempt_o     = preempt_q;
  end

endmodule
